load_store_unit: RTL and testbench

Memory stage directly downstream of the RV32I datapath. It consumes the ALU result (effective address), writeData, f3 and the memory control strobes, and performs the access on a word-wide request/acknowledge data-memory bus. It returns the aligned, sign- or zero-extended readData to the datapath's result mux, and asserts stall to freeze pc and register writes while a multi-cycle access is in flight.

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory stage: drives a word-wide req/ack data bus for loads and stores and stalls the core meanwhile.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of silently aligning them.
module load_store_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              memWrite,
  input  logic [2:0]        f3,
  input  logic [31:0]       addr,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WADDR_W = ADDR_W - 2;
  localparam int unsigned CNT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;

  logic        f3_legal_c;
  logic        trap_c;
  logic [1:0]  off_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_ext_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic        addr_unused;

  assign addr_unused = ^addr[31:ADDR_W];

  assign f3_legal_c = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (((f3 == 3'b100) || (f3 == 3'b101)) && !memWrite);

`ifdef MISALIGN_TRAP_EN
  assign trap_c = ((f3[1:0] == 2'b01) && addr[0]) ||
                  ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // Byte offset forced to natural alignment; only differs from addr[1:0] when untrapped misaligned.
  always_comb begin
    off_c   = addr[1:0];
    be_c    = 4'b1111;
    wdata_c = writeData;
    case (f3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{writeData[7:0]}};
      end
      2'b01: begin
        off_c   = {addr[1], 1'b0};
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{writeData[15:0]}};
      end
      default: off_c = 2'b00;
    endcase
    if (!memWrite) be_c = 4'b1111;
  end

  // Lane select and extension of the returned word using the latched access shape.
  always_comb begin
    ld_half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (off_q)
      2'b00:   ld_byte_c = mem_rdata[7:0];
      2'b01:   ld_byte_c = mem_rdata[15:8];
      2'b10:   ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    case (f3_q)
      3'b000:  load_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  load_ext_c = {24'd0, ld_byte_c};
      3'b001:  load_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  load_ext_c = {16'd0, ld_half_c};
      default: load_ext_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (!f3_legal_c || trap_c) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = memWrite;
            mem_addr_d  = addr[ADDR_W-1:2];
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            f3_d        = f3;
            off_d       = off_c;
            cnt_d       = '0;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          rdata_d   = mem_we_q ? 32'd0 : load_ext_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MAX_WAIT)) begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            rdata_d   = 32'd0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign readData  = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a spec-level model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.ADDR_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .memWrite(memWrite), .f3(f3), .addr(addr),
    .writeData(writeData), .readData(readData), .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations of the most recent access
  int          o_stalls, o_busy;
  logic        o_req_seen, o_stable, o_timeout, o_we, o_err;
  logic [13:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wd, o_rd;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic logic m_fault(input logic we, input logic [2:0] fn, input logic [31:0] a);
    logic illegal, misal;
    illegal = (fn == 3'd3) || (fn == 3'd6) || (fn == 3'd7) || (we && fn[2]);
    misal   = ((fn[1:0] == 2'd1) && (a % 2 != 0)) || ((fn[1:0] == 2'd2) && (a % 4 != 0));
    return illegal || (TRAP && misal);
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] fn, input logic [31:0] a);
    int lane;
    if (!we) return 4'hF;
    lane = int'(a % 4);
    if (fn[1:0] == 2'd0) return 4'((1 << lane));
    if (fn[1:0] == 2'd1) return 4'((3 << ((lane / 2) * 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] fn, input logic [31:0] wd);
    if (fn[1:0] == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (fn[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rd);
    int lane;
    logic [31:0] v;
    lane = (fn[1:0] == 2'd0) ? int'(a % 4) : (fn[1:0] == 2'd1) ? int'((a % 4) / 2) * 2 : 0;
    v = rd >> (8 * lane);
    case (fn)
      3'd0: return ((v & 32'h80) != 0) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
      3'd4: return v & 32'hFF;
      3'd1: return ((v & 32'h8000) != 0) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
      3'd5: return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // Drives one access from a negedge and records what the bus and core interface did (ack_wait<0: never ack).
  task automatic run_access(input logic we, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_wait);
    o_stalls = 0; o_busy = 0; o_req_seen = 1'b0; o_stable = 1'b1; o_timeout = 1'b1;
    o_addr = '0; o_be = '0; o_we = 1'b0; o_wd = '0; o_rd = '0; o_err = 1'b0;
    req = 1'b1; memWrite = we; f3 = fn; addr = a; writeData = wd; mem_rdata = rd;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) begin
        o_timeout = 1'b0; o_rd = readData; o_err = err;
        break;
      end
      o_stalls++;
      if (mem_req) begin
        if (!o_req_seen) begin
          o_req_seen = 1'b1; o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wd = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {o_addr, o_be, o_we, o_wd}) begin
          o_stable = 1'b0;
        end
        mem_ack = (o_busy == ack_wait);
        o_busy++;
      end
      @(posedge clk); #1;
      req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    tests_run++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, readData, err, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wd=%h rd=%h err=%b stall=%b, expected all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, readData, err, stall);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw_wait;
    run_access(1'b1, 3'd2, 32'h0010, 32'hDEADBEEF, 32'h0, 1);
    tests_run++;
    if ({o_addr, o_be, o_we, o_wd} !== {14'h004, 4'hF, 1'b1, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL sw_bus: got addr=%h be=%h we=%b wd=%h, expected 004 f 1 deadbeef", o_addr, o_be, o_we, o_wd);
    end
    tests_run++;
    if (o_stalls !== 3 || o_timeout || o_err !== 1'b0 || !o_stable) begin
      tests_failed++;
      $display("FAIL sw_stall: got stalls=%0d timeout=%b err=%b stable=%b, expected 3 0 0 1",
               o_stalls, o_timeout, o_err, o_stable);
    end
    tests_run++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_idle: got mem_req=%b stall=%b, expected 0 0", mem_req, stall);
    end
  endtask

  task automatic test_load_ext;
    run_access(1'b0, 3'd0, 32'h0013, 32'h0, 32'h80FF1234, 0);
    tests_run++;
    if (o_rd !== 32'hFFFFFF80 || o_stalls !== 2 || o_err !== 1'b0 || o_be !== 4'hF || o_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb: got rd=%h stalls=%0d err=%b be=%h we=%b, expected ffffff80 2 0 f 0",
               o_rd, o_stalls, o_err, o_be, o_we);
    end
    run_access(1'b0, 3'd4, 32'h0013, 32'h0, 32'h80FF1234, 0);
    tests_run++;
    if (o_rd !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL lbu: got %h expected 00000080", o_rd);
    end
    run_access(1'b0, 3'd5, 32'h0012, 32'h0, 32'h80FF1234, 0);
    tests_run++;
    if (o_rd !== 32'h000080FF) begin
      tests_failed++;
      $display("FAIL lhu: got %h expected 000080ff", o_rd);
    end
  endtask

  task automatic test_sh;
    run_access(1'b1, 3'd1, 32'h0006, 32'h1234ABCD, 32'h0, 0);
    tests_run++;
    if ({o_addr, o_be, o_wd, o_rd} !== {14'h001, 4'b1100, 32'hABCDABCD, 32'h0}) begin
      tests_failed++;
      $display("FAIL sh: got addr=%h be=%b wd=%h rd=%h, expected 001 1100 abcdabcd 0", o_addr, o_be, o_wd, o_rd);
    end
  endtask

  task automatic test_misaligned;
    run_access(1'b0, 3'd2, 32'h0002, 32'h0, 32'hCAFEF00D, 0);
    tests_run++;
    if (TRAP) begin
      if (o_req_seen || o_err !== 1'b1 || o_rd !== 32'h0 || o_stalls !== 1) begin
        tests_failed++;
        $display("FAIL lw_misalign_trap: got req_seen=%b err=%b rd=%h stalls=%0d, expected 0 1 0 1",
                 o_req_seen, o_err, o_rd, o_stalls);
      end
    end else begin
      if (o_addr !== 14'h000 || o_be !== 4'hF || o_rd !== 32'hCAFEF00D || o_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL lw_misalign: got addr=%h be=%h rd=%h err=%b, expected 000 f cafef00d 0",
                 o_addr, o_be, o_rd, o_err);
      end
    end
  endtask

  task automatic test_illegal_f3;
    run_access(1'b0, 3'd7, 32'h0100, 32'h0, 32'h12345678, 0);
    tests_run++;
    if (o_req_seen || o_err !== 1'b1 || o_rd !== 32'h0 || o_stalls !== 1) begin
      tests_failed++;
      $display("FAIL illegal_f3: got req_seen=%b err=%b rd=%h stalls=%0d, expected 0 1 0 1",
               o_req_seen, o_err, o_rd, o_stalls);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'd2, 32'h0040, 32'h0, 32'h5555AAAA, -1);
    tests_run++;
    if (o_busy !== 15 || o_stalls !== 16 || o_err !== 1'b1 || o_rd !== 32'h0 || o_timeout) begin
      tests_failed++;
      $display("FAIL timeout: got busy=%0d stalls=%0d err=%b rd=%h hung=%b, expected 15 16 1 0 0",
               o_busy, o_stalls, o_err, o_rd, o_timeout);
    end
    mem_ack = 1'b1; mem_rdata = 32'h13572468;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b1 || readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL late_ack: got mem_req=%b stall=%b err=%b rd=%h, expected 0 0 1 0", mem_req, stall, err, readData);
    end
  endtask

  task automatic test_reset_mid_busy;
    req = 1'b1; memWrite = 1'b1; f3 = 3'd2; addr = 32'h0080; writeData = 32'h0BADF00D;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    tests_run++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_before_rst: got mem_req=%b stall=%b, expected 1 1", mem_req, stall);
    end
    rst = 1'b1; #1;
    tests_run++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || mem_be !== 4'h0) begin
      tests_failed++;
      $display("FAIL async_rst: got mem_req=%b stall=%b be=%h, expected 0 0 0", mem_req, stall, mem_be);
    end
    @(negedge clk); rst = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_ack: got mem_req=%b stall=%b err=%b, expected 0 0 0", mem_req, stall, err);
    end
    run_access(1'b0, 3'd2, 32'h0020, 32'h0, 32'h2468ACE0, 0);
    tests_run++;
    if (o_addr !== 14'h008 || o_rd !== 32'h2468ACE0 || o_err !== 1'b0 || o_stalls !== 2) begin
      tests_failed++;
      $display("FAIL lw_after_rst: got addr=%h rd=%h err=%b stalls=%0d, expected 008 2468ace0 0 2",
               o_addr, o_rd, o_err, o_stalls);
    end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  fn;
    logic [31:0] a, wd, rd, e_rd;
    int          aw;
    logic        flt;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      fn = 3'($urandom_range(0, 7));
      a  = $urandom & 32'h0000FFFF;
      wd = $urandom;
      rd = $urandom;
      aw = $urandom_range(0, 3);
      flt = m_fault(we, fn, a);
      run_access(we, fn, a, wd, rd, aw);
      tests_run++;
      if (flt) begin
        if (o_req_seen || o_err !== 1'b1 || o_rd !== 32'h0 || o_stalls !== 1) begin
          tests_failed++;
          $display("FAIL rand_fault[%0d] we=%b f3=%0d a=%h: got req_seen=%b err=%b rd=%h stalls=%0d, expected 0 1 0 1",
                   i, we, fn, a, o_req_seen, o_err, o_rd, o_stalls);
        end
      end else begin
        e_rd = we ? 32'h0 : m_load(fn, a, rd);
        if (o_addr !== 14'(a >> 2) || o_be !== m_be(we, fn, a) || o_we !== we ||
            (we && o_wd !== m_wd(fn, wd)) || o_rd !== e_rd || o_err !== 1'b0 ||
            o_stalls !== 2 + aw || !o_stable) begin
          tests_failed++;
          $display("FAIL rand_access[%0d] we=%b f3=%0d a=%h: got addr=%h be=%h wd=%h rd=%h err=%b stalls=%0d stable=%b, expected addr=%h be=%h wd=%h rd=%h err=0 stalls=%0d",
                   i, we, fn, a, o_addr, o_be, o_wd, o_rd, o_err, o_stalls, o_stable,
                   14'(a >> 2), m_be(we, fn, a), m_wd(fn, wd), e_rd, 2 + aw);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_sw_wait;
    test_load_ext;
    test_sh;
    test_misaligned;
    test_illegal_f3;
    test_timeout;
    test_reset_mid_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
